register16b_ip_cores: RTL and testbench



---
 rtl/register16b_ip_cores_if.sv | 21 ++
 rtl/register16b_ip_cores.sv | 69 ++++++
 tb/tb_register16b_ip_cores.sv | 128 ++++++++++++
 3 files changed

// File: rtl/register16b_ip_cores_if.sv
// rtl/register16b_ip_cores_if.sv - halfword read/write port bundle for register16b_ip_cores
interface register16b_ip_cores_if #(
  parameter int ADDR_W = 4,
  parameter int HALF_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              write_en;
  logic [HALF_W-1:0] write_data;
  logic [HALF_W-1:0] read_data_1;
  logic              is_little_endian;

  modport master (
    output addr, write_en, write_data, is_little_endian,
    input  read_data_1
  );

  modport slave (
    input  addr, write_en, write_data, is_little_endian,
    output read_data_1
  );
endinterface

// File: rtl/register16b_ip_cores.sv
// rtl/register16b_ip_cores.sv - 8x32 memory on a 16-bit halfword port with runtime endianness
// Optional: REG16B_BYTE_SWAP_EN swaps bytes within the halfword in little-endian mode.
module register16b_ip_cores #(
  parameter int                   ADDR_W    = 4,
  parameter int                   HALF_W    = 16,
  parameter logic [2*HALF_W-1:0]  LAST_WORD = 32'h12345678
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register16b_ip_cores_if.slave bus
);
  localparam int WORD_W = 2 * HALF_W;
  localparam int WORDS  = 1 << (ADDR_W - 1);

  logic [WORD_W-1:0] mem [WORDS];
  logic [ADDR_W-2:0] word_idx;
  logic              upper_sel;
  logic              swap_en;
  logic [HALF_W-1:0] sel_half;
  logic [HALF_W-1:0] rd_half;
  logic [HALF_W-1:0] wr_half;

  // Word i holds the byte ramp 4i..4i+3; the top word is a fixed marker.
  function automatic logic [WORD_W-1:0] init_word(input int i);
    if (i == WORDS - 1) begin
      return LAST_WORD;
    end
    return WORD_W'({8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)});
  endfunction

  function automatic logic [HALF_W-1:0] byte_swap(input logic [HALF_W-1:0] h);
    return {h[7:0], h[15:8]};
  endfunction

  assign word_idx  = bus.addr[ADDR_W-1:1];
  // Big endian puts the even halfword in the upper half; little endian inverts that.
  assign upper_sel = ~(bus.addr[0] ^ bus.is_little_endian);

`ifdef REG16B_BYTE_SWAP_EN
  assign swap_en = bus.is_little_endian;
`else
  assign swap_en = 1'b0;
`endif

  always_comb begin
    sel_half = upper_sel ? mem[word_idx][WORD_W-1:HALF_W] : mem[word_idx][HALF_W-1:0];
    rd_half  = swap_en ? byte_swap(sel_half) : sel_half;
    wr_half  = swap_en ? byte_swap(bus.write_data) : bus.write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.read_data_1 <= '0;
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= init_word(i);
      end
    end else if (bus.write_en) begin
      if (upper_sel) begin
        mem[word_idx][WORD_W-1:HALF_W] <= wr_half;
      end else begin
        mem[word_idx][HALF_W-1:0] <= wr_half;
      end
      // Write-first: the swap is undone on the way back out, so echo the port data.
      bus.read_data_1 <= bus.write_data;
    end else begin
      bus.read_data_1 <= rd_half;
    end
  end
endmodule

// File: tb/tb_register16b_ip_cores.sv
// tb/tb_register16b_ip_cores.sv - directed self-checking bench for register16b_ip_cores
module tb_register16b_ip_cores;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  register16b_ip_cores_if bus ();

  register16b_ip_cores dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected little-endian view of a stored big-endian halfword.
  function automatic logic [15:0] le_view(input logic [15:0] h);
`ifdef REG16B_BYTE_SWAP_EN
    return {h[7:0], h[15:8]};
`else
    return h;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic le, input logic [3:0] a, input logic [15:0] exp);
    bus.is_little_endian = le;
    bus.addr             = a;
    bus.write_en         = 1'b0;
    step();
    check(tag, bus.read_data_1, exp);
  endtask

  task automatic wr(input string tag, input logic le, input logic [3:0] a, input logic [15:0] d);
    bus.is_little_endian = le;
    bus.addr             = a;
    bus.write_data       = d;
    bus.write_en         = 1'b1;
    step();
    check(tag, bus.read_data_1, d);
    bus.write_en = 1'b0;
  endtask

  initial begin
    checks               = 0;
    errors               = 0;
    rst_n                = 1'b1;
    bus.addr             = '0;
    bus.write_en         = 1'b0;
    bus.write_data       = '0;
    bus.is_little_endian = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_rd", bus.read_data_1, 16'h0000);
    bus.write_en   = 1'b1;
    bus.write_data = 16'hDEAD;
    step();
    check("reset_wr_ignored", bus.read_data_1, 16'h0000);
    bus.write_en = 1'b0;
    rst_n        = 1'b1;

    rd("be_a0", 1'b0, 4'd0, 16'h0001);
    rd("be_a1", 1'b0, 4'd1, 16'h0203);
    rd("le_a0", 1'b1, 4'd0, le_view(16'h0203));
    rd("le_a1", 1'b1, 4'd1, le_view(16'h0001));
    rd("le_a15", 1'b1, 4'd15, le_view(16'h1234));
    rd("le_a14", 1'b1, 4'd14, le_view(16'h5678));
    rd("le_a13", 1'b1, 4'd13, le_view(16'h1819));
    rd("be_a14", 1'b0, 4'd14, 16'h1234);
    rd("be_a15", 1'b0, 4'd15, 16'h5678);
    rd("be_a12", 1'b0, 4'd12, 16'h1819);

    bus.addr = 4'd1;
    for (int i = 0; i < 4; i++) begin
      bus.write_data = 16'h1111 * i[15:0];
      step();
      check("no_we_hold", bus.read_data_1, 16'h0203);
    end

    wr("be_wr_a1", 1'b0, 4'd1, 16'h4141);
    rd("be_after_wr_a0", 1'b0, 4'd0, 16'h0001);
    rd("be_after_wr_a1", 1'b0, 4'd1, 16'h4141);
    rd("le_after_wr_a0", 1'b1, 4'd0, le_view(16'h4141));
    rd("le_after_wr_a1", 1'b1, 4'd1, le_view(16'h0001));

    wr("le_wr_a2", 1'b1, 4'd2, 16'hBEEF);
    rd("le_rb_a2", 1'b1, 4'd2, 16'hBEEF);
    rd("be_view_a3", 1'b0, 4'd3, le_view(16'hBEEF));
    rd("be_view_a2", 1'b0, 4'd2, 16'h0405);

    wr("be_wr_a15", 1'b0, 4'd15, 16'hCAFE);
    rd("be_a14_kept", 1'b0, 4'd14, 16'h1234);
    rd("be_a15_new", 1'b0, 4'd15, 16'hCAFE);

    bus.addr = 4'd1;
    step();
    check("pre_reset_rd", bus.read_data_1, 16'h4141);
    #3 rst_n = 1'b0;
    #1 check("async_reset", bus.read_data_1, 16'h0000);
    bus.write_en   = 1'b1;
    bus.write_data = 16'h7777;
    step();
    check("reset_wins_wr", bus.read_data_1, 16'h0000);
    bus.write_en = 1'b0;
    rst_n        = 1'b1;
    rd("post_reset_a1", 1'b0, 4'd1, 16'h0203);
    rd("post_reset_a0", 1'b0, 4'd0, 16'h0001);
    rd("post_reset_a3", 1'b0, 4'd3, 16'h0607);
    rd("post_reset_a15", 1'b0, 4'd15, 16'h5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
